// File: rtl/exu_pkg.sv
// Shared types and constants for the execution-unit issue/writeback scheduler.
// The op encoding doubles as the writeback-select encoding.
package exu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    EXU_ALU = 2'b00,
    EXU_MDU = 2'b01,
    EXU_FPU = 2'b10
  } exu_op_e;

  typedef exu_op_e wb_sel_t;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    wb_sel_t               sel;
  } wb_t;

endpackage

// File: rtl/exu_issue_ctrl_if.sv
// Decoder-to-scheduler bundle: decoded op fields in, issue/stall/start/writeback out.
// The decoder side uses the master modport; the scheduler uses slave.
interface exu_issue_ctrl_if;
  import exu_pkg::*;

  logic                  iValid;
  logic [1:0]            iExuOp;
  logic                  iEnWrite;
  logic [REG_ADDR_W-1:0] iAddrWrite;
  logic                  iEnRead0;
  logic [REG_ADDR_W-1:0] iAddrRead0;
  logic                  iEnRead1;
  logic [REG_ADDR_W-1:0] iAddrRead1;
  logic                  iFlush;

  logic                  oIssue;
  logic                  oStall;
  logic                  oMduStart;
  logic                  oFpuStart;
  logic                  oMduBusy;
  logic                  oFpuBusy;
  logic                  oWbEn;
  logic [REG_ADDR_W-1:0] oWbAddr;
  logic [1:0]            oWbSel;

  modport master (
    output iValid, iExuOp, iEnWrite, iAddrWrite, iEnRead0, iAddrRead0,
           iEnRead1, iAddrRead1, iFlush,
    input  oIssue, oStall, oMduStart, oFpuStart, oMduBusy, oFpuBusy,
           oWbEn, oWbAddr, oWbSel
  );

  modport slave (
    input  iValid, iExuOp, iEnWrite, iAddrWrite, iEnRead0, iAddrRead0,
           iEnRead1, iAddrRead1, iFlush,
    output oIssue, oStall, oMduStart, oFpuStart, oMduBusy, oFpuBusy,
           oWbEn, oWbAddr, oWbSel
  );

endinterface

// File: rtl/exu_scoreboard.sv
// Pending-destination scoreboard for the multi-cycle units: one set port,
// one clear port, three combinational lookups. Set wins over clear.
module exu_scoreboard
  import exu_pkg::*;
(
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rd0_addr_i,
  input  logic [REG_ADDR_W-1:0] rd1_addr_i,
  input  logic [REG_ADDR_W-1:0] wr_addr_i,
  output logic                  rd0_pend_o,
  output logic                  rd1_pend_o,
  output logic                  wr_pend_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  // NOTE: combinational blocks assign a default first, so no path leaves a latch.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end

  // NOTE: the pending vector is plain flops and is reset; a stale bit would stall forever.
  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign rd0_pend_o = pend_q[rd0_addr_i];
  assign rd1_pend_o = pend_q[rd1_addr_i];
  assign wr_pend_o  = pend_q[wr_addr_i];

  // A register is never reissued while pending, so set and clear never meet.
  a_no_set_clr_same: assert property (@(posedge iClk) disable iff (!iRst_n)
    !(set_en_i && clr_en_i && (set_addr_i == clr_addr_i)));

endmodule

// File: rtl/exu_issue_ctrl.sv
// Issue gate and writeback scheduler: hazard detection, MDU/FPU countdown
// trackers and the single registered register-file write port.
module exu_issue_ctrl
  import exu_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int FPU_LAT = 6
) (
  input  logic            iClk,
  input  logic            iRst_n,
  exu_issue_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MDU_LAT > FPU_LAT) ? MDU_LAT : FPU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t                  cnt;
    logic                  wr;
    logic [REG_ADDR_W-1:0] dest;
  } unit_t;

  localparam cnt_t CNT_ONE     = cnt_t'(1);
  localparam cnt_t MDU_LOAD    = cnt_t'(MDU_LAT - 1);
  localparam cnt_t FPU_LOAD    = cnt_t'(FPU_LAT - 1);
  localparam cnt_t MDU_LAT_CNT = cnt_t'(MDU_LAT);
  localparam cnt_t FPU_LAT_CNT = cnt_t'(FPU_LAT);

  unit_t mdu_q, mdu_d, fpu_q, fpu_d;
  wb_t   wb_q, wb_d;

  logic is_alu, is_mdu, is_fpu;
  logic rd0_pend, rd1_pend, wr_pend;
  logic hazard, accept, issue;
  logic mdu_start, fpu_start, alu_wb, mdu_done, fpu_done;

  assign is_alu = (bus.iExuOp == EXU_ALU);
  assign is_mdu = (bus.iExuOp == EXU_MDU);
  assign is_fpu = (bus.iExuOp == EXU_FPU);

  exu_scoreboard u_scoreboard (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .set_en_i   ((mdu_start | fpu_start) & bus.iEnWrite),
    .set_addr_i (bus.iAddrWrite),
    .clr_en_i   (wb_q.en & (wb_q.sel != EXU_ALU)),
    .clr_addr_i (wb_q.addr),
    .rd0_addr_i (bus.iAddrRead0),
    .rd1_addr_i (bus.iAddrRead1),
    .wr_addr_i  (bus.iAddrWrite),
    .rd0_pend_o (rd0_pend),
    .rd1_pend_o (rd1_pend),
    .wr_pend_o  (wr_pend)
  );

  // A unit may take a new op in the cycle its previous one hands off (cnt==1);
  // the last two terms keep a new writeback off a slot already claimed.
  assign hazard = bus.iValid & (
      (bus.iEnRead0 & rd0_pend)
    | (bus.iEnRead1 & rd1_pend)
    | (bus.iEnWrite & wr_pend)
    | (is_mdu & (mdu_q.cnt > CNT_ONE))
    | (is_fpu & (fpu_q.cnt > CNT_ONE))
    | (is_alu & bus.iEnWrite & ((mdu_q.cnt == CNT_ONE) | (fpu_q.cnt == CNT_ONE)))
    | (is_mdu & (fpu_q.cnt == MDU_LAT_CNT))
    | (is_fpu & (mdu_q.cnt == FPU_LAT_CNT)));

  assign accept    = iRst_n & bus.iValid & ~bus.iFlush;
  assign issue     = accept & ~hazard;
  assign mdu_start = issue & is_mdu;
  assign fpu_start = issue & is_fpu;
  assign alu_wb    = issue & is_alu & bus.iEnWrite;
  assign mdu_done  = (mdu_q.cnt == CNT_ONE) & mdu_q.wr;
  assign fpu_done  = (fpu_q.cnt == CNT_ONE) & fpu_q.wr;

  always_comb begin
    mdu_d = mdu_q;
    fpu_d = fpu_q;
    wb_d  = '{en: 1'b0, addr: '0, sel: EXU_ALU};

    if (mdu_start) begin
      mdu_d.cnt  = MDU_LOAD;
      mdu_d.wr   = bus.iEnWrite;
      mdu_d.dest = bus.iAddrWrite;
    end else if (mdu_q.cnt != '0) begin
      mdu_d.cnt = mdu_q.cnt - CNT_ONE;
    end

    if (fpu_start) begin
      fpu_d.cnt  = FPU_LOAD;
      fpu_d.wr   = bus.iEnWrite;
      fpu_d.dest = bus.iAddrWrite;
    end else if (fpu_q.cnt != '0) begin
      fpu_d.cnt = fpu_q.cnt - CNT_ONE;
    end

    // At most one source is live; the stall rules guarantee it.
    if (mdu_done) begin
      wb_d = '{en: 1'b1, addr: mdu_q.dest, sel: EXU_MDU};
    end else if (fpu_done) begin
      wb_d = '{en: 1'b1, addr: fpu_q.dest, sel: EXU_FPU};
    end else if (alu_wb) begin
      wb_d = '{en: 1'b1, addr: bus.iAddrWrite, sel: EXU_ALU};
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      mdu_q <= '0;
      fpu_q <= '0;
      wb_q  <= '{en: 1'b0, addr: '0, sel: EXU_ALU};
    end else begin
      mdu_q <= mdu_d;
      fpu_q <= fpu_d;
      wb_q  <= wb_d;
    end
  end

  assign bus.oIssue    = issue;
  assign bus.oStall    = accept & hazard;
  assign bus.oMduStart = mdu_start;
  assign bus.oFpuStart = fpu_start;
  assign bus.oMduBusy  = (mdu_q.cnt != '0);
  assign bus.oFpuBusy  = (fpu_q.cnt != '0);
  assign bus.oWbEn     = wb_q.en;
  assign bus.oWbAddr   = wb_q.addr;
  assign bus.oWbSel    = wb_q.sel;

  a_wb_single_source: assert property (@(posedge iClk) disable iff (!iRst_n)
    $onehot0({alu_wb, mdu_done, fpu_done}));

endmodule
